// File: rtl/inport_buffer.sv
// inport_buffer: router input port FIFO with first-word fall-through head, XY route label and back-pressure.
// Optional flit counter output enabled by defining INPORT_STATS_EN.
module inport_buffer #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 2,
  parameter int DATASIZE  = 30,
  parameter int router_ID = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                full,
  output logic [DATASIZE-1:0] data_out,
  output logic [4:0]          label,
  input  logic                ready,
  output logic                overflow
`ifdef INPORT_STATS_EN
  ,
  output logic [15:0]         flit_cnt
`endif
);
  localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);
  localparam logic [1:0] X = 2'(router_ID);
  localparam logic [1:0] Y = 2'(router_ID >> 2);
  logic [DATASIZE-1:0] ram [DEPTH];
  logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0] count_q, count_d;
  logic full_q, full_d, overflow_q, overflow_d, push, pop;
  logic [3:0] dest;
  always_comb begin
    push       = valid_in && count_q != DEPTH_C;
    pop        = ready && count_q != '0;
    wr_ptr_d   = wr_ptr_q + WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + WIDTH'(pop);
    count_d    = count_q + (WIDTH+1)'(push) - (WIDTH+1)'(pop);
    // one spare slot covers the flit already in the upstream output register
    full_d     = count_d >= DEPTH_C - 1'b1;
    overflow_d = overflow_q || (valid_in && count_q == DEPTH_C);
    data_out   = count_q != '0 ? ram[rd_ptr_q] : '0;
    dest       = data_out[DATASIZE-1 -: 4];
    label      = count_q == '0  ? 5'b00000 :
                 dest[1:0] > X ? 5'b01000 :
                 dest[1:0] < X ? 5'b00010 :
                 dest[3:2] > Y ? 5'b10000 :
                 dest[3:2] < Y ? 5'b00100 : 5'b00001;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr_q] <= data_in;
  end
  assign full     = full_q;
  assign overflow = overflow_q;
`ifdef INPORT_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;
  always_comb flit_cnt_d = flit_cnt_q + 16'(push && flit_cnt_q != 16'hFFFF);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flit_cnt_q <= '0;
    else flit_cnt_q <= flit_cnt_d;
  end
  assign flit_cnt = flit_cnt_q;
`endif
endmodule
